// File: rtl/btn_pkg.sv
// Shared types and default board timing for the push-button step generator.
// All timing values are in CLK100MHZ cycles.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms at 100 MHz
    localparam int DEF_REPEAT_DELAY    = 50_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;  // 100 ms

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/btn_step_gen_sync_debounce.sv
// Two-flop synchronizer followed by a stability counter; level follows the
// synchronized button only after it has held a new value for DEBOUNCE_CYCLES.
module sync_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic fall_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;

    // Synchronizer and debounce counter; any bounce back to level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= ~level_r;
                    cnt_r   <= CNT_ZERO;
                end else begin
                    cnt_r   <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= CNT_ZERO;
            end
        end
    end

    assign level = level_r;
    // High in the cycle right before level drops, so a coincident repeat tick can be suppressed.
    assign fall_next = level_r & ~sync2_r & (cnt_r == CNT_LAST);

endmodule

// File: rtl/btn_step_gen.sv
// Debounced push-button to single-cycle step pulses with optional auto-repeat.
// The release output is named release_pulse because release is a reserved word.
module btn_step_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic btn_in,
    output logic level,
    output logic step,
    output logic release_pulse
);

    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] R_ONE       = RW'(1);
    localparam logic [RW-1:0] R_ZERO      = {RW{1'b0}};

    logic          level_s;
    logic          fall_next_s;
    btn_state_t    state_r;
    logic [RW-1:0] rcnt_r;
    logic          step_r;
    logic          release_r;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk       (CLK100MHZ),
        .rst_n     (CPU_RESETN),
        .btn_in    (btn_in),
        .level     (level_s),
        .fall_next (fall_next_s)
    );

    // Press/hold/repeat FSM; a level fall always beats a repeat tick.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_r   <= IDLE;
            rcnt_r    <= R_ZERO;
            step_r    <= 1'b0;
            release_r <= 1'b0;
        end else begin
            step_r    <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    rcnt_r <= R_ZERO;
                    if (level_s) begin
                        step_r  <= 1'b1;
                        state_r <= HOLD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                HOLD: begin
                    if (!level_s) begin
                        release_r <= 1'b1;
                        state_r   <= IDLE;
                        rcnt_r    <= R_ZERO;
                    end else if (rcnt_r == DELAY_LAST) begin
                        // Counter parks at its last value when repeat is off or a fall is imminent.
                        if (REPEAT_EN && !fall_next_s) begin
                            step_r  <= 1'b1;
                            state_r <= REPEAT;
                            rcnt_r  <= R_ZERO;
                        end else begin
                            state_r <= HOLD;
                        end
                    end else begin
                        rcnt_r <= rcnt_r + R_ONE;
                    end
                end
                REPEAT: begin
                    if (!level_s) begin
                        release_r <= 1'b1;
                        state_r   <= IDLE;
                        rcnt_r    <= R_ZERO;
                    end else if (rcnt_r == PERIOD_LAST) begin
                        if (!fall_next_s) begin
                            step_r <= 1'b1;
                            rcnt_r <= R_ZERO;
                        end else begin
                            state_r <= REPEAT;
                        end
                    end else begin
                        rcnt_r <= rcnt_r + R_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rcnt_r  <= R_ZERO;
                end
            endcase
        end
    end

    assign level         = level_s;
    assign step          = step_r;
    assign release_pulse = release_r;

endmodule

// File: doc/btn_step_gen.md
Name: btn_step_gen

Overview:
Input-side counterpart to the board's seven-segment output path. Takes a raw, bouncy push-button (e.g. BTNC) and produces clean, single-cycle step pulses in the CLK100MHZ domain, with optional auto-repeat while the button is held. Downstream counters use `step` as a clock enable, so they stay on CLK100MHZ and no button is used as a clock.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized input must stay stable before `level` follows it (10 ms at 100 MHz)
REPEAT_EN, 1, 1 enables auto-repeat while held; 0 gives exactly one step per press
REPEAT_DELAY, 50_000_000, cycles from `level` rise to the first repeat step (500 ms)
REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat steps (100 ms)

Ports:
CLK100MHZ  input  1  system clock, all logic on rising edge
CPU_RESETN  input  1  reset, asynchronous assert, active-low
btn_in  input  1  raw button, asynchronous to CLK100MHZ, may bounce
level  output  1  debounced button level
step  output  1  one-cycle pulse per press and per auto-repeat tick
release  output  1  one-cycle pulse when the debounced level falls

Behaviour:
- Reset (CPU_RESETN low) asynchronously clears all state: synchronizer flops, counters, FSM, and outputs. During reset, level=0, step=0, release=0.
- Synchronizer: two flops, sync2 = btn_in delayed by 2 cycles.
- Debounce counter:
  - Width is $clog2(DEBOUNCE_CYCLES).
  - Increments each cycle that sync2 != level.
  - Clears in any cycle where sync2 == level (bounce restarts the count).
  - When the count equals DEBOUNCE_CYCLES-1 and sync2 still differs, level toggles on the next edge and the counter clears.
  - A held change on btn_in appears on level 2+DEBOUNCE_CYCLES cycles later.
- FSM states IDLE, HOLD, REPEAT:
  - IDLE: on level rise (level 0->1, seen at cycle L), step=1 at L+1. Go to HOLD and clear the repeat counter.
  - HOLD: the repeat counter increments. When REPEAT_EN=1 and the count reaches REPEAT_DELAY-1, pulse step and go to REPEAT. The first repeat step is at L+1+REPEAT_DELAY.
  - REPEAT: pulse step every REPEAT_PERIOD cycles, i.e. at L+1+REPEAT_DELAY+k*REPEAT_PERIOD.
  - REPEAT_EN=0: remain in HOLD with no further steps.
  - Any state with level falling at cycle F: release=1 at F+1, go to IDLE, clear the repeat counter.
- Priority: a level fall wins over repeat-timer expiry in the same cycle (release, no step). step and release are never high together.
- Reset mid-hold with btn_in still 1: after deassert, the synchronizer refills from 0. level rises at deassert+2+DEBOUNCE_CYCLES and a fresh step follows one cycle later. This is intended, not a glitch.
- Repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). It never wraps, because it is cleared on every transition.
- All outputs are registered; no combinational path from btn_in.
- Parameters ≥ 2 are required. The bench uses small values.

Decomposition:
- Package btn_pkg:
  - typedef enum logic [1:0] {IDLE, HOLD, REPEAT} btn_state_t
  - default constants for the debounce, delay and period values (board timing at 100 MHz)
- Sub-module sync_debounce (DEBOUNCE_CYCLES): synchronizer plus debounce counter, outputs level.
- btn_step_gen instantiates sync_debounce and holds the FSM, repeat counter and output registers.

Test Plan:
(bench params DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_EN=1, reset released at cycle 0)
1. Clean press: btn_in=1 at cycles 0..9, then 0 -> level=1 at 6, step only at 7, level=0 at 16, release only at 17, no other pulses.
2. Bounce: btn_in toggles every 2 cycles for 20 cycles, then stays 0 -> level, step and release stay 0 throughout.
3. Auto-repeat: btn_in=1 at cycles 0..55, then 0 -> steps at exactly 7, 27, 35, 43, 51, 59. level falls at 62, release at 63, no step after 63.
4. REPEAT_EN=0, btn_in=1 for 60 cycles -> exactly one step (cycle 7), release at 67.
5. Reset mid-hold: btn_in=1 from 0, CPU_RESETN low at cycle 30 for 3 cycles (deassert at 33) -> level and step drop to 0 immediately. level=1 again at 39, step at 40.
6. Release on repeat boundary: btn_in drops so that level falls at cycle 27 (the first-repeat cycle) -> release at 28, no step at 27 or 28.
